// File: rtl/div_sub_seq_pkg.sv
// ----------------------------------------------------------------------------
// div_sub_seq_pkg
// Shared definitions for the sequential subtract/divide unit: default operand
// width, FSM state encoding and the operation-select constants. The select
// constants share their encoding with the combinational add/multiply block
// (0 = add/subtract, 1 = multiply/divide).
// ----------------------------------------------------------------------------
package div_sub_seq_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SUB  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam logic OP_SUM_SUB = 1'b0;
    localparam logic OP_MUL_DIV = 1'b1;

    // True for the states in which an operation is in flight.
    function automatic logic is_busy_state(input state_e s);
        return (s == ST_SUB) || (s == ST_DIV);
    endfunction

endpackage

// File: rtl/div_sub_seq_div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One combinational iteration of unsigned restoring division.
//   rem_i  : partial remainder from the previous iteration (always < div_i)
//   bit_i  : next dividend bit, MSB first
//   div_i  : divisor
//   rem_o  : new partial remainder
//   q_o    : quotient bit produced by this iteration
// The shifted remainder is formed at W+1 bits so the compare against the
// divisor cannot overflow; once the divisor is subtracted (or not) the result
// is again below the divisor and fits in W bits.
// ----------------------------------------------------------------------------
module div_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] div_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0] shifted_s;
    logic       ge_s;

    assign shifted_s = {rem_i, bit_i};
    assign ge_s      = (shifted_s >= {1'b0, div_i});

    // Restore-or-subtract decision for this bit.
    always_comb begin
        rem_o = shifted_s[W-1:0];
        q_o   = 1'b0;
        if (ge_s) begin
            // When ge_s holds the difference is below div_i, so the top bit
            // of shifted_s cancels and the low W bits give the exact result.
            rem_o = shifted_s[W-1:0] - div_i;
            q_o   = 1'b1;
        end else begin
            rem_o = shifted_s[W-1:0];
            q_o   = 1'b0;
        end
    end

endmodule

// File: rtl/div_sub_seq.sv
// ----------------------------------------------------------------------------
// div_sub_seq
// Sequential inverse-arithmetic unit: A - B (one cycle) or unsigned restoring
// A / B (WIDTH cycles, one quotient bit per cycle, MSB first).
//
// Ports
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   start  : request strobe, only sampled in IDLE
//   A, B   : minuend/dividend, subtrahend/divisor (latched on start)
//   sel    : 0 = subtract, 1 = divide
//   busy   : high while SUB or DIV is in progress
//   done   : one-cycle pulse in the cycle the results first become valid
//   saida  : difference or quotient (held until next result or reset)
//   resto  : remainder, 0 after a subtraction
//   err    : divide-by-zero flag
//
// Optional feature macro: DIV_ZERO_DETECT_EN
//   When defined, a zero divisor finishes in the first DIV cycle with
//   saida = all ones, resto = A and err = 1. When undefined, a zero divisor
//   runs all WIDTH iterations (yielding the same saida/resto) and err stays 0.
// ----------------------------------------------------------------------------
module div_sub_seq
    import div_sub_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] saida,
    output logic [WIDTH-1:0] resto,
    output logic             err
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;       // dividend, shifted left one bit per iteration
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] saida_q, saida_d;
    logic [WIDTH-1:0] resto_q, resto_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_rem_s;
    logic             step_q_s;
    logic [WIDTH-1:0] quo_next_s;
    logic             zero_div_s;

    div_step #(
        .W(WIDTH)
    ) u_div_step (
        .rem_i (rem_q),
        .bit_i (a_q[WIDTH-1]),
        .div_i (b_q),
        .rem_o (step_rem_s),
        .q_o   (step_q_s)
    );

    assign quo_next_s = {quo_q[WIDTH-2:0], step_q_s};

`ifdef DIV_ZERO_DETECT_EN
    assign zero_div_s = (b_q == {WIDTH{1'b0}});
`else
    assign zero_div_s = 1'b0;
`endif

    // Next-state, datapath and output-register update logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        saida_d = saida_q;
        resto_d = resto_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    rem_d   = {WIDTH{1'b0}};
                    quo_d   = {WIDTH{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = (sel == OP_MUL_DIV) ? ST_DIV : ST_SUB;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SUB: begin
                saida_d = a_q - b_q;   // borrow discarded: wraps mod 2^WIDTH
                resto_d = {WIDTH{1'b0}};
                err_d   = 1'b0;
                state_d = ST_DONE;
            end

            ST_DIV: begin
                // Early exit only reachable in the first cycle: a_q is still
                // the unshifted dividend because the check precedes any shift.
                if (zero_div_s) begin
                    saida_d = {WIDTH{1'b1}};
                    resto_d = a_q;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    rem_d = step_rem_s;
                    quo_d = quo_next_s;
                    a_d   = {a_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == LAST_ITER) begin
                        saida_d = quo_next_s;
                        resto_d = step_rem_s;
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // busy/done are registered decodes of the state being entered so
        // they line up exactly with that state's cycle.
        busy_d = is_busy_state(state_d);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            quo_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            saida_q <= {WIDTH{1'b0}};
            resto_q <= {WIDTH{1'b0}};
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            saida_q <= saida_d;
            resto_q <= resto_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign saida = saida_q;
    assign resto = resto_q;
    assign err   = err_q;

endmodule

// File: tb/tb_div_sub_seq.sv
// ----------------------------------------------------------------------------
// tb_div_sub_seq
// Self-checking bench for div_sub_seq. A cycle-level behavioural model
// (plain arithmetic on the accepted operands plus edge bookkeeping) predicts
// busy/done/saida/resto/err every cycle; directed tests add literal checks.
// ----------------------------------------------------------------------------
module tb_div_sub_seq;

`ifdef DIV_ZERO_DETECT_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a_in = 16'h0000;
    logic [15:0] b_in = 16'h0000;
    logic        sel_in = 1'b0;
    logic        busy, done, err;
    logic [15:0] saida, resto;

    int n_pass  = 0;
    int n_total = 0;

    div_sub_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .sel   (sel_in),
        .busy  (busy),
        .done  (done),
        .saida (saida),
        .resto (resto),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total = n_total + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int          ed        = 0;     // number of rising edges so far
    int          m_acc     = -100;  // edge at which the current op was accepted
    int          m_res     = -1;    // edge at which its results are written
    int          m_next_ok = 0;     // first edge at which a new start is accepted
    logic [15:0] p_saida = 16'h0000, p_resto = 16'h0000;
    logic        p_err = 1'b0;
    logic [15:0] x_saida = 16'h0000, x_resto = 16'h0000;
    logic        x_err = 1'b0;

    function automatic int op_len(input logic s, input logic [15:0] b);
        if (s == 1'b0) return 1;
        if (ZD && b == 16'h0000) return 1;
        return 16;
    endfunction

    always @(posedge clk) begin
        ed <= ed + 1;
        if (rst) begin
            x_saida   <= 16'h0000;
            x_resto   <= 16'h0000;
            x_err     <= 1'b0;
            m_acc     <= -100;
            m_res     <= -1;
            m_next_ok <= ed + 2;
        end else begin
            if (start && (ed + 1) >= m_next_ok) begin
                m_acc     <= ed + 1;
                m_res     <= ed + 1 + op_len(sel_in, b_in);
                m_next_ok <= ed + 3 + op_len(sel_in, b_in);
                if (sel_in == 1'b0) begin
                    p_saida <= a_in - b_in;
                    p_resto <= 16'h0000;
                    p_err   <= 1'b0;
                end else if (b_in == 16'h0000) begin
                    p_saida <= 16'hFFFF;
                    p_resto <= a_in;
                    p_err   <= ZD;
                end else begin
                    p_saida <= a_in / b_in;
                    p_resto <= a_in % b_in;
                    p_err   <= 1'b0;
                end
            end
            if ((ed + 1) == m_res) begin
                x_saida <= p_saida;
                x_resto <= p_resto;
                x_err   <= p_err;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (ed >= 1) begin
            chk("busy",  {31'd0, busy}, {31'd0, (ed >= m_acc) && (ed < m_res)});
            chk("done",  {31'd0, done}, {31'd0, (ed == m_res)});
            chk("saida", {16'd0, saida}, {16'd0, x_saida});
            chk("resto", {16'd0, resto}, {16'd0, x_resto});
            chk("err",   {31'd0, err},   {31'd0, x_err});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
        @(posedge clk); #2;
        a_in = a; b_in = b; sel_in = s; start = 1'b1;
        @(posedge clk); #2;
        start  = 1'b0;
        a_in   = 16'($urandom);
        b_in   = 16'($urandom);
        sel_in = 1'($urandom);
    endtask

    // Counts cycles after the sampling edge until done; also counts busy cycles.
    task automatic wait_done(output int lat, output int nbusy);
        lat = 0; nbusy = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) nbusy = nbusy + 1;
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            n_total = n_total + 1;
            $display("FAIL done_timeout: got no done within 40 cycles, expected a pulse");
        end
    endtask

    typedef struct { logic [15:0] a; logic [15:0] b; logic s; } vec_t;
    vec_t vecs[4];

    int lat, nbusy, extra;

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b1};
        vecs[1] = '{16'd12345, 16'd123, 1'b1};
        vecs[2] = '{16'd7, 16'd9, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b1};

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy",  {31'd0, busy}, 32'd0);
        chk("reset_saida", {16'd0, saida}, 32'd0);

        // Subtract 5-3
        issue(16'd5, 16'd3, 1'b0);
        wait_done(lat, nbusy);
        chk("sub_lat",   lat, 32'd2);
        chk("sub_saida", {16'd0, saida}, 32'd2);
        chk("sub_resto", {16'd0, resto}, 32'd0);
        chk("sub_err",   {31'd0, err}, 32'd0);

        // Wrap-around 2-3
        issue(16'd2, 16'd3, 1'b0);
        wait_done(lat, nbusy);
        chk("wrap_saida", {16'd0, saida}, 32'h0000FFFF);
        chk("wrap_resto", {16'd0, resto}, 32'd0);

        // Divide 4/2
        issue(16'd4, 16'd2, 1'b1);
        wait_done(lat, nbusy);
        chk("div_lat",   lat, 32'd17);
        chk("div_busy",  nbusy, 32'd16);
        chk("div_saida", {16'd0, saida}, 32'd2);
        chk("div_resto", {16'd0, resto}, 32'd0);

        // Divide 100/7 with a rejected start while busy
        issue(16'd100, 16'd7, 1'b1);
        repeat (3) @(posedge clk);
        #2 a_in = 16'd50; b_in = 16'd5; sel_in = 1'b0; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        wait_done(lat, nbusy);
        chk("rem_saida", {16'd0, saida}, 32'd14);
        chk("rem_resto", {16'd0, resto}, 32'd2);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) extra = extra + 1;
        end
        chk("rejected_start_done", extra, 32'd0);

        // Divide by zero
        issue(16'h1234, 16'h0000, 1'b1);
        wait_done(lat, nbusy);
        chk("dz_lat",   lat, ZD ? 32'd2 : 32'd17);
        chk("dz_saida", {16'd0, saida}, 32'h0000FFFF);
        chk("dz_resto", {16'd0, resto}, 32'h00001234);
        chk("dz_err",   {31'd0, err}, {31'd0, ZD});

        // Subtract clears err
        issue(16'd9, 16'd4, 1'b0);
        wait_done(lat, nbusy);
        chk("clr_saida", {16'd0, saida}, 32'd5);
        chk("clr_err",   {31'd0, err}, 32'd0);

        // Table of boundary divides, checked by the per-cycle model
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].s);
            wait_done(lat, nbusy);
        end
        chk("tbl_last_saida", {16'd0, saida}, 32'd1);
        chk("tbl_last_resto", {16'd0, resto}, 32'd0);

        // Reset during iteration 8 of 100/7
        issue(16'd100, 16'd7, 1'b1);
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_saida", {16'd0, saida}, 32'd0);
        chk("rst_resto", {16'd0, resto}, 32'd0);
        chk("rst_err",   {31'd0, err}, 32'd0);
        issue(16'd100, 16'd7, 1'b1);
        wait_done(lat, nbusy);
        chk("post_rst_lat",   lat, 32'd17);
        chk("post_rst_saida", {16'd0, saida}, 32'd14);
        chk("post_rst_resto", {16'd0, resto}, 32'd2);

        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
